// File: rtl/iommu_ip_gen.sv
// Interrupt generation stage: keeps ipsr pending bits (cip, fip, pmip) with
// RW1C clearing and routes each pending source through its icvec vector to
// either wired interrupt lines or a single-outstanding MSI request channel.
module iommu_ip_gen #(
  parameter int unsigned N_INT_VEC   = 16,
  parameter int unsigned LOG2_INTVEC = (N_INT_VEC > 1) ? $clog2(N_INT_VEC) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cq_ip_evt_i,
  input  logic                 fq_ip_evt_i,
  input  logic                 hpm_ip_evt_i,
  input  logic                 cqcsr_cie_i,
  input  logic                 fqcsr_fie_i,
  input  logic                 ipsr_wr_i,
  input  logic [2:0]           ipsr_wdata_i,
  input  logic [3:0]           icvec_civ_i,
  input  logic [3:0]           icvec_fiv_i,
  input  logic [3:0]           icvec_pmiv_i,
  input  logic                 fctl_wsi_i,
  output logic [2:0]           ipsr_o,
  output logic [N_INT_VEC-1:0] wsi_o,
  output logic                 msi_req_o,
  output logic [3:0]           msi_vec_o,
  input  logic                 msi_gnt_i,
  output logic                 msi_busy_o
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t               state_q, state_d;
  logic [2:0]           ipsr_q, ipsr_d;
  logic [2:0]           pend_q, pend_d;
  logic [N_INT_VEC-1:0] wsi_q, wsi_d;
  logic [1:0]           src_q, src_d;
  logic [3:0]           vec_q, vec_d;
  logic [2:0]           set_mask, clr_mask, rise, issued, gnt_mask;
  logic [3:0]           src_vec [3];

  // Vector fields wrap modulo the number of implemented vectors.
  function automatic logic [LOG2_INTVEC-1:0] vec_idx(input logic [3:0] v);
    return LOG2_INTVEC'(32'(v) % N_INT_VEC);
  endfunction

  // Per-source set/clear requests and the resulting pending-bit update.
  always_comb begin
    src_vec[0] = icvec_civ_i;
    src_vec[1] = icvec_fiv_i;
    src_vec[2] = icvec_pmiv_i;
    set_mask   = {hpm_ip_evt_i, fq_ip_evt_i & fqcsr_fie_i, cq_ip_evt_i & cqcsr_cie_i};
    clr_mask   = ipsr_wr_i ? ipsr_wdata_i : '0;
    // Set has priority over a same-cycle clear.
    ipsr_d     = set_mask | (ipsr_q & ~clr_mask);
    rise       = ipsr_d & ~ipsr_q;
  end

  // Wired interrupt lines: OR of pending sources mapped to each vector.
  always_comb begin
    wsi_d = '0;
    if (fctl_wsi_i) begin
      for (int unsigned s = 0; s < 3; s++) begin
        if (ipsr_q[s]) wsi_d[vec_idx(src_vec[s])] = 1'b1;
      end
    end
  end

  // MSI arming: edge-triggered; a source in flight keeps its pend bit
  // until granted so a SW clear cannot drop an issued request.
  always_comb begin
    issued   = (state_q == REQ) ? (3'b001 << src_q) : '0;
    gnt_mask = (state_q == REQ && msi_gnt_i) ? issued : '0;
    if (fctl_wsi_i) pend_d = '0;
    else            pend_d = (pend_q & ~(clr_mask & ~issued) & ~gnt_mask) | rise;
  end

  // MSI FSM next state: fixed priority cip > fip > pmip, one outstanding.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (!fctl_wsi_i && (|pend_q)) begin
          if (pend_q[0])      src_d = 2'd0;
          else if (pend_q[1]) src_d = 2'd1;
          else                src_d = 2'd2;
          vec_d   = 4'(vec_idx(src_vec[src_d]));
          state_d = REQ;
        end
      end
      REQ: begin
        if (msi_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pending registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ipsr_q  <= '0;
      pend_q  <= '0;
      wsi_q   <= '0;
      src_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      ipsr_q  <= ipsr_d;
      pend_q  <= pend_d;
      wsi_q   <= wsi_d;
      src_q   <= src_d;
      vec_q   <= vec_d;
    end
  end

  assign ipsr_o     = ipsr_q;
  assign wsi_o      = wsi_q;
  assign msi_req_o  = (state_q == REQ);
  assign msi_busy_o = (state_q != IDLE);
  assign msi_vec_o  = vec_q;

endmodule

// File: tb/tb_iommu_ip_gen.sv
// Self-checking bench for iommu_ip_gen: a 16-vector and a 4-vector instance
// share stimulus; ipsr/wsi are checked against a behavioural model, MSI
// traffic against vectors expected from the issued sources.
module tb_iommu_ip_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cq_ip_evt_i, fq_ip_evt_i, hpm_ip_evt_i;
  logic        cqcsr_cie_i, fqcsr_fie_i;
  logic        ipsr_wr_i;
  logic [2:0]  ipsr_wdata_i;
  logic [3:0]  icvec_civ_i, icvec_fiv_i, icvec_pmiv_i;
  logic        fctl_wsi_i;
  logic        msi_gnt_i;

  logic [2:0]  ipsr_o, ipsr4;
  logic [15:0] wsi_o;
  logic [3:0]  wsi4;
  logic        msi_req_o, req4, msi_busy_o, busy4;
  logic [3:0]  msi_vec_o, vec4;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [2:0]  m_ipsr;
  logic [15:0] m_wsi16;
  logic [3:0]  m_wsi4;

  iommu_ip_gen #(.N_INT_VEC(16)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cq_ip_evt_i(cq_ip_evt_i), .fq_ip_evt_i(fq_ip_evt_i), .hpm_ip_evt_i(hpm_ip_evt_i),
    .cqcsr_cie_i(cqcsr_cie_i), .fqcsr_fie_i(fqcsr_fie_i),
    .ipsr_wr_i(ipsr_wr_i), .ipsr_wdata_i(ipsr_wdata_i),
    .icvec_civ_i(icvec_civ_i), .icvec_fiv_i(icvec_fiv_i), .icvec_pmiv_i(icvec_pmiv_i),
    .fctl_wsi_i(fctl_wsi_i), .ipsr_o(ipsr_o), .wsi_o(wsi_o),
    .msi_req_o(msi_req_o), .msi_vec_o(msi_vec_o), .msi_gnt_i(msi_gnt_i),
    .msi_busy_o(msi_busy_o)
  );

  iommu_ip_gen #(.N_INT_VEC(4)) u_dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cq_ip_evt_i(cq_ip_evt_i), .fq_ip_evt_i(fq_ip_evt_i), .hpm_ip_evt_i(hpm_ip_evt_i),
    .cqcsr_cie_i(cqcsr_cie_i), .fqcsr_fie_i(fqcsr_fie_i),
    .ipsr_wr_i(ipsr_wr_i), .ipsr_wdata_i(ipsr_wdata_i),
    .icvec_civ_i(icvec_civ_i), .icvec_fiv_i(icvec_fiv_i), .icvec_pmiv_i(icvec_pmiv_i),
    .fctl_wsi_i(fctl_wsi_i), .ipsr_o(ipsr4), .wsi_o(wsi4),
    .msi_req_o(req4), .msi_vec_o(vec4), .msi_gnt_i(msi_gnt_i),
    .msi_busy_o(busy4)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wired lines implied by a set of pending bits for n implemented vectors.
  function automatic logic [15:0] wsi_of(input logic [2:0] ip, input int n);
    logic [15:0] r = '0;
    if (ip[0]) r[int'(icvec_civ_i)  % n] = 1'b1;
    if (ip[1]) r[int'(icvec_fiv_i)  % n] = 1'b1;
    if (ip[2]) r[int'(icvec_pmiv_i) % n] = 1'b1;
    return r;
  endfunction

  // One clock: advance the model with the current inputs, then clear pulses.
  task automatic cyc();
    logic [2:0]  set_m, clr_m;
    logic [15:0] w16, w4;
    set_m = {hpm_ip_evt_i, fq_ip_evt_i & fqcsr_fie_i, cq_ip_evt_i & cqcsr_cie_i};
    clr_m = ipsr_wr_i ? ipsr_wdata_i : 3'b000;
    w16   = fctl_wsi_i ? wsi_of(m_ipsr, 16) : 16'h0;
    w4    = fctl_wsi_i ? wsi_of(m_ipsr, 4)  : 16'h0;
    @(posedge clk_i);
    #1;
    m_ipsr  = set_m | (m_ipsr & ~clr_m);
    m_wsi16 = w16;
    m_wsi4  = w4[3:0];
    cq_ip_evt_i = 1'b0; fq_ip_evt_i = 1'b0; hpm_ip_evt_i = 1'b0;
    ipsr_wr_i = 1'b0; ipsr_wdata_i = 3'b000;
  endtask

  task automatic chk_model(input string tag);
    check({tag, "_ipsr"},  32'(ipsr_o), 32'(m_ipsr));
    check({tag, "_wsi"},   32'(wsi_o),  32'(m_wsi16));
    check({tag, "_ipsr4"}, 32'(ipsr4),  32'(m_ipsr));
    check({tag, "_wsi4"},  32'(wsi4),   32'(m_wsi4));
  endtask

  task automatic sw_clear(input logic [2:0] bits);
    ipsr_wr_i = 1'b1; ipsr_wdata_i = bits;
    cyc();
  endtask

  // Wait (bounded) for a request, hold the grant off, check stability, grant.
  task automatic wait_req(input string tag, input logic [3:0] ev, input int hold);
    int n = 0;
    while (!msi_req_o && n < 20) begin cyc(); n++; end
    check({tag, "_seen"}, 32'(msi_req_o), 32'd1);
    if (msi_req_o) begin
      check({tag, "_vec"},  32'(msi_vec_o), 32'(ev));
      check({tag, "_vec4"}, 32'(vec4), 32'(ev & 4'h3));
      check({tag, "_busy"}, 32'(msi_busy_o), 32'd1);
      for (int i = 0; i < hold; i++) begin
        cyc();
        check({tag, "_hold_req"}, 32'(msi_req_o), 32'd1);
        check({tag, "_hold_vec"}, 32'(msi_vec_o), 32'(ev));
      end
      msi_gnt_i = 1'b1;
      cyc();
      msi_gnt_i = 1'b0;
      check({tag, "_drop_req"},  32'(msi_req_o),  32'd0);
      check({tag, "_drop_busy"}, 32'(msi_busy_o), 32'd0);
    end
  endtask

  task automatic no_req(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cyc();
      check(tag, 32'(msi_req_o), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] rv;
    int unsigned s;
    rst_ni = 1'b0;
    cq_ip_evt_i = 1'b0; fq_ip_evt_i = 1'b0; hpm_ip_evt_i = 1'b0;
    cqcsr_cie_i = 1'b0; fqcsr_fie_i = 1'b0;
    ipsr_wr_i = 1'b0; ipsr_wdata_i = 3'b000;
    icvec_civ_i = 4'd0; icvec_fiv_i = 4'd0; icvec_pmiv_i = 4'd0;
    fctl_wsi_i = 1'b1; msi_gnt_i = 1'b0;
    m_ipsr = '0; m_wsi16 = '0; m_wsi4 = '0;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ipsr", 32'(ipsr_o), 32'd0);
    check("rst_wsi",  32'(wsi_o),  32'd0);
    check("rst_req",  32'(msi_req_o), 32'd0);
    check("rst_vec",  32'(msi_vec_o), 32'd0);
    check("rst_busy", 32'(msi_busy_o), 32'd0);
    rst_ni = 1'b1;

    // WSI basic set / RW1C clear latency
    icvec_civ_i = 4'd3; cqcsr_cie_i = 1'b1;
    cq_ip_evt_i = 1'b1;
    cyc();
    check("t1_ipsr_c1", 32'(ipsr_o), 32'd1);
    check("t1_wsi_c1",  32'(wsi_o),  32'd0);
    cyc();
    check("t1_wsi_c2",  32'(wsi_o),  32'h0008);
    repeat (3) cyc();
    sw_clear(3'b001);
    check("t1_ipsr_c6", 32'(ipsr_o), 32'd0);
    check("t1_wsi_c6",  32'(wsi_o),  32'h0008);
    cyc();
    check("t1_wsi_c7",  32'(wsi_o),  32'h0000);

    // Same-cycle set and clear: set wins
    hpm_ip_evt_i = 1'b1; ipsr_wr_i = 1'b1; ipsr_wdata_i = 3'b100;
    cyc();
    check("t2_set_wins", 32'(ipsr_o), 32'h4);
    hpm_ip_evt_i = 1'b1; ipsr_wr_i = 1'b1; ipsr_wdata_i = 3'b100;
    cyc();
    check("t2_set_wins_again", 32'(ipsr_o), 32'h4);
    ipsr_wr_i = 1'b1; ipsr_wdata_i = 3'b011;
    cyc();
    check("t2_clr_zero_noeffect", 32'(ipsr_o), 32'h4);
    sw_clear(3'b100);
    check("t2_clr", 32'(ipsr_o), 32'h0);
    cyc();

    // Vector wrap with N_INT_VEC=4, shared vector
    icvec_pmiv_i = 4'd6; icvec_civ_i = 4'd2;
    cq_ip_evt_i = 1'b1; hpm_ip_evt_i = 1'b1;
    cyc(); cyc();
    check("t6_wsi4", 32'(wsi4), 32'h4);
    check("t6_wsi16", 32'(wsi_o), 32'h44);
    sw_clear(3'b100);
    cyc();
    check("t6_wsi4_keep", 32'(wsi4), 32'h4);
    check("t6_wsi16_keep", 32'(wsi_o), 32'h04);
    chk_model("t6");
    sw_clear(3'b111);
    cyc();

    // Randomized WSI traffic against the model
    for (int i = 0; i < 300; i++) begin
      cq_ip_evt_i  = ($urandom_range(0, 3) == 0);
      fq_ip_evt_i  = ($urandom_range(0, 3) == 0);
      hpm_ip_evt_i = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) cqcsr_cie_i = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 7) == 0) fqcsr_fie_i = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 7) == 0) icvec_civ_i  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) icvec_fiv_i  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) icvec_pmiv_i = 4'($urandom_range(0, 15));
      ipsr_wr_i    = ($urandom_range(0, 2) == 0);
      ipsr_wdata_i = 3'($urandom_range(0, 7));
      cyc();
      chk_model("rnd_wsi");
      check("rnd_wsi_noreq", 32'(msi_req_o), 32'd0);
    end
    sw_clear(3'b111);
    cyc();
    chk_model("rnd_wsi_end");

    // MSI: two sources at once, priority fip over pmip
    fctl_wsi_i = 1'b0; cqcsr_cie_i = 1'b1; fqcsr_fie_i = 1'b1;
    icvec_fiv_i = 4'd5; icvec_pmiv_i = 4'd9;
    fq_ip_evt_i = 1'b1; hpm_ip_evt_i = 1'b1;
    cyc();
    wait_req("t3_first", 4'd5, 3);
    cyc();
    check("t3_second_req", 32'(msi_req_o), 32'd1);
    wait_req("t3_second", 4'd9, 1);
    no_req("t3_quiet", 4);
    chk_model("t3");
    sw_clear(3'b111);

    // MSI: edge-triggered, repeats while pending do not re-issue
    rv = 4'($urandom_range(0, 15));
    icvec_civ_i = rv;
    for (int i = 0; i < 3; i++) begin cq_ip_evt_i = 1'b1; cyc(); end
    wait_req("t4_first", rv, 2);
    for (int i = 0; i < 6; i++) begin
      cq_ip_evt_i = 1'b1;
      cyc();
      check("t4_no_repeat", 32'(msi_req_o), 32'd0);
    end
    sw_clear(3'b001);
    cq_ip_evt_i = 1'b1;
    cyc();
    wait_req("t4_second", rv, 0);
    no_req("t4_quiet", 3);
    sw_clear(3'b111);

    // Randomized single-source MSI requests
    for (int i = 0; i < 10; i++) begin
      s  = $urandom_range(0, 2);
      rv = 4'($urandom_range(0, 15));
      if (s == 0) begin icvec_civ_i  = rv; cq_ip_evt_i  = 1'b1; end
      if (s == 1) begin icvec_fiv_i  = rv; fq_ip_evt_i  = 1'b1; end
      if (s == 2) begin icvec_pmiv_i = rv; hpm_ip_evt_i = 1'b1; end
      cyc();
      check("rnd_msi_ipsr", 32'(ipsr_o), 32'(3'b001 << s));
      wait_req("rnd_msi", rv, $urandom_range(0, 4));
      sw_clear(3'b111);
    end

    // MSI -> WSI switch during an outstanding request
    icvec_civ_i = 4'd1; icvec_fiv_i = 4'd7;
    cq_ip_evt_i = 1'b1; fq_ip_evt_i = 1'b1;
    cyc();
    while (!msi_req_o && total < 100000) cyc();
    fctl_wsi_i = 1'b1;
    wait_req("sw_wsi", 4'd1, 2);
    no_req("sw_wsi_quiet", 5);
    check("sw_wsi_lines", 32'(wsi_o), 32'h0082);
    chk_model("sw_wsi");

    // WSI -> MSI switch with bits already pending: nothing issued
    fctl_wsi_i = 1'b0;
    no_req("sw_msi_quiet", 5);
    check("sw_msi_wsi_off", 32'(wsi_o), 32'h0);
    sw_clear(3'b001);
    cq_ip_evt_i = 1'b1;
    cyc();
    wait_req("sw_msi_retrig", 4'd1, 0);
    sw_clear(3'b111);

    // Stuck request, SW clear during REQ, then async reset mid-REQ
    icvec_civ_i = 4'd2;
    cq_ip_evt_i = 1'b1;
    cyc();
    begin
      int n = 0;
      while (!msi_req_o && n < 20) begin cyc(); n++; end
    end
    check("t5_seen", 32'(msi_req_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin ipsr_wr_i = 1'b1; ipsr_wdata_i = 3'b001; end
      cyc();
      check("t5_req_stable", 32'(msi_req_o), 32'd1);
      check("t5_vec_stable", 32'(msi_vec_o), 32'd2);
    end
    check("t5_cip_cleared", 32'(ipsr_o), 32'd0);
    cq_ip_evt_i = 1'b1;
    cyc();
    check("t5_cip_set", 32'(ipsr_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t5_rst_ipsr", 32'(ipsr_o), 32'd0);
    check("t5_rst_wsi",  32'(wsi_o),  32'd0);
    check("t5_rst_req",  32'(msi_req_o), 32'd0);
    check("t5_rst_vec",  32'(msi_vec_o), 32'd0);
    check("t5_rst_busy", 32'(msi_busy_o), 32'd0);
    check("t5_rst_req4", 32'(req4), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    m_ipsr = '0; m_wsi16 = '0; m_wsi4 = '0;
    no_req("t5_after_rst", 4);
    chk_model("t5_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iommu_ip_gen.md
Name: iommu_ip_gen

Overview:
Interrupt-generation stage directly downstream of the HPM and queue handlers. It consumes the HPM interrupt pulse, plus the command-queue and fault-queue interrupt pulses, and keeps the ipsr pending bits (cip, fip, pmip) with SW RW1C clearing. Each pending source is routed through its icvec vector to either wired interrupts (WSI) or a single-outstanding MSI request channel (valid/grant) toward the MSI writer.

Parameters:
N_INT_VEC, 16, number of implemented interrupt vectors (1..16); a vector index v is taken as icvec field modulo N_INT_VEC.
LOG2_INTVEC, $clog2(N_INT_VEC) (min 1), width of internal vector index.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cq_ip_evt_i  in  1  command-queue interrupt condition pulse
fq_ip_evt_i  in  1  fault-queue interrupt condition pulse
hpm_ip_evt_i  in  1  HPM overflow interrupt pulse (ipsr.pmip set request)
cqcsr_cie_i  in  1  CQ interrupt enable
fqcsr_fie_i  in  1  FQ interrupt enable
ipsr_wr_i  in  1  SW write strobe to ipsr
ipsr_wdata_i  in  3  {pmip,fip,cip} write data, RW1C
icvec_civ_i  in  4  CQ vector
icvec_fiv_i  in  4  FQ vector
icvec_pmiv_i  in  4  HPM vector
fctl_wsi_i  in  1  1 = WSI mode, 0 = MSI mode
ipsr_o  out  3  {pmip,fip,cip} pending bits
wsi_o  out  N_INT_VEC  wired interrupt lines
msi_req_o  out  1  MSI request valid
msi_vec_o  out  4  vector of current MSI request
msi_gnt_i  in  1  MSI writer accepts request
msi_busy_o  out  1  MSI FSM not IDLE

Behaviour:
- Reset (async, rst_ni=0): ipsr_o=0, wsi_o=0, msi_req_o=0, msi_vec_o=0, msi_busy_o=0, all msi_pend=0, FSM=IDLE.
- Set condition per bit: cip <- cq_ip_evt_i & cqcsr_cie_i; fip <- fq_ip_evt_i & fqcsr_fie_i; pmip <- hpm_ip_evt_i (no enable). Registered; visible on ipsr_o next cycle.
- Clear: ipsr_wr_i & ipsr_wdata_i[b] clears bit b next cycle. Writing 0 has no effect.
- Same-cycle set and clear on one bit: set wins, bit stays/becomes 1.
- WSI path (fctl_wsi_i=1): wsi_o[v] registered = OR over sources s with ipsr[s]=1 and (vec_s mod N_INT_VEC)==v. One cycle latency from ipsr_o change. Multiple sources can share a vector. In MSI mode wsi_o=0 (registered).
- MSI arming (fctl_wsi_i=0): a 0->1 transition of ipsr bit s sets msi_pend[s]. A set request while the bit is already 1 produces no new edge and no new MSI. SW clear of ipsr[s] clears msi_pend[s] if that source is not currently issued. In WSI mode all msi_pend are held at 0.
- MSI FSM states:
  - IDLE: if any msi_pend, select by fixed priority cip > fip > pmip. Latch source and vector (mod N_INT_VEC) into msi_vec_o, assert msi_req_o, go to REQ.
  - REQ: msi_req_o=1. msi_vec_o is stable until msi_gnt_i. The request is never withdrawn, even if SW clears ipsr or the mode switches. On msi_gnt_i, clear msi_pend of the issued source, deassert msi_req_o next cycle, go to IDLE.
- Minimum one IDLE cycle between successive requests. Max one outstanding MSI.
- msi_busy_o = (state != IDLE).
- Mode switch MSI->WSI during REQ: the current request completes. Remaining msi_pend are cleared. wsi_o reflects ipsr from the next cycle.
- Mode switch WSI->MSI with bits already pending: no MSI is generated (edge-triggered). SW must clear and re-trigger.
- icvec value >= N_INT_VEC wraps modulo N_INT_VEC (e.g. N_INT_VEC=4, civ=6 -> vector 2).

Test Plan:
1. WSI, civ=3, cie=1, cq_ip_evt pulse at cycle 0 -> ipsr_o=3'b001 at cycle 1, wsi_o[3]=1 at cycle 2. SW write 3'b001 at cycle 5 -> ipsr_o=0 at cycle 6, wsi_o=0 at cycle 7.
2. Same-cycle hpm_ip_evt pulse and ipsr write 3'b100 -> pmip remains 1.
3. MSI mode, fiv=5, pmiv=9, fq_ip_evt and hpm_ip_evt pulsed together with fie=1 -> msi_req_o with msi_vec_o=5 held until gnt. Then one IDLE cycle, then a request with msi_vec_o=9.
4. MSI mode, repeated cq_ip_evt pulses while cip=1 -> exactly one request. After SW clear and a new pulse -> a second request.
5. MSI REQ outstanding (vec 2), msi_gnt_i held 0 for 10 cycles while SW clears cip -> msi_req_o and msi_vec_o=2 stay stable until gnt. rst_ni asserted mid-REQ -> all outputs 0 immediately.
6. N_INT_VEC=4, WSI, pmiv=6 and civ=2 both pending -> only wsi_o[2]=1. Clear pmip only -> wsi_o[2] stays 1.
